// File: rtl/apb_pkg.sv
// Shared APB definitions used by the requester and the team's APB slave.
package apb_pkg;

  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Counter must reach TIMEOUT; a disabled timeout still needs a legal 1-bit width.
  function automatic int timer_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the ACCESS phase; expire flags the last allowed stall cycle.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam int CW = timer_width(TIMEOUT);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt;

      always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en)    cnt <= cnt + CW'(1);
      end

      assign expire = (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/apb_master.sv
// APB requester: one valid/ready command in, one SETUP/ACCESS transfer out, one response pulse back.
module apb_master
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  apb_state_e state;
  logic       accept;
  logic       expire;

  assign cmd_ready = (state == IDLE) && !preset;
  assign accept    = cmd_valid && cmd_ready;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (pclk),
    .rst    (preset),
    .clr    (accept),
    .en     ((state == ACCESS) && !pready),
    .expire (expire)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            pwrite  <= cmd_write;
            paddr   <= cmd_addr;
            pwdata  <= cmd_wdata;
            psel    <= 1'b1;
            penable <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // Address/data stay registered after completion; only the strobes drop.
          if (pready) begin
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= IDLE;
          end else if (expire) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master against a transaction-level model of latency and response.
module tb_apb_master;

  localparam int TMO = 16;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] last_rd;
  logic        last_err;

  apb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Called in a cycle where the master should be ready; returns in the response cycle.
  task automatic do_xfer(input logic w, input logic [7:0] a, input logic [31:0] d, input int waits);
    int          cyc;
    logic        exp_err;
    logic [31:0] rd, exp_rd;
    rd      = $urandom;
    exp_err = (TMO != 0) && (waits >= TMO);
    cyc     = exp_err ? TMO : waits + 1;
    exp_rd  = (exp_err || w) ? 32'h0 : rd;

    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    pready = 1'($urandom_range(0, 1));
    #1 chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    tick();

    cmd_valid = 1'($urandom_range(0, 1)); cmd_write = ~w;
    cmd_addr = 8'hFF; cmd_wdata = $urandom; pready = 1'($urandom_range(0, 1));
    #1;
    chk("setup_psel", 32'(psel), 32'd1);
    chk("setup_penable", 32'(penable), 32'd0);
    chk("setup_paddr", 32'(paddr), 32'(a));
    chk("setup_pwrite", 32'(pwrite), 32'(w));
    chk("setup_pwdata", pwdata, d);
    chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();

    for (int i = 0; i < cyc; i++) begin
      pready = (i == waits);
      prdata = (i == waits) ? rd : $urandom;
      cmd_addr = $urandom; cmd_write = $urandom; cmd_valid = 1'($urandom_range(0, 1));
      #1;
      chk("access_psel", 32'(psel), 32'd1);
      chk("access_penable", 32'(penable), 32'd1);
      chk("access_paddr", 32'(paddr), 32'(a));
      chk("access_pwrite", 32'(pwrite), 32'(w));
      chk("access_pwdata", pwdata, d);
      chk("access_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("access_rsp_valid", 32'(rsp_valid), 32'd0);
      tick();
    end

    cmd_valid = 1'b0; pready = 1'b0;
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_psel", 32'(psel), 32'd0);
    chk("rsp_penable", 32'(penable), 32'd0);
    chk("rsp_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rsp_paddr_hold", 32'(paddr), 32'(a));
    chk("rsp_pwrite_hold", 32'(pwrite), 32'(w));
    last_rd  = exp_rd;
    last_err = exp_err;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      pready = 1'($urandom_range(0, 1));
      tick();
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("idle_psel", 32'(psel), 32'd0);
      chk("idle_rsp_rdata_hold", rsp_rdata, last_rd);
      chk("idle_rsp_err_hold", 32'(rsp_err), 32'(last_err));
      chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    end
  endtask

  task automatic reset_mid_access(input int stall);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h33; cmd_wdata = 32'h0;
    tick();
    cmd_valid = 1'b0; pready = 1'b0;
    tick();
    for (int i = 0; i < stall; i++) tick();
    preset = 1'b1;
    #1 chk("rst_cmd_ready_low", 32'(cmd_ready), 32'd0);
    tick();
    preset = 1'b0;
    #1;
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    last_rd  = 32'h0;
    last_err = 1'b0;
    idle(3);
  endtask

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = 1'b0;
    tick(); tick();
    chk("reset_psel", 32'(psel), 32'd0);
    chk("reset_penable", 32'(penable), 32'd0);
    chk("reset_pwrite", 32'(pwrite), 32'd0);
    chk("reset_paddr", 32'(paddr), 32'd0);
    chk("reset_pwdata", pwdata, 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    preset = 1'b0;
    last_rd = 32'h0; last_err = 1'b0;

    do_xfer(1'b1, 8'h10, 32'hDEADBEEF, 0);   idle(2);
    do_xfer(1'b0, 8'h04, 32'h0, 3);          idle(1);
    do_xfer(1'b0, 8'h20, 32'h0, 40);         idle(1);
    do_xfer(1'b0, 8'h21, 32'h0, TMO - 1);    idle(1);
    reset_mid_access(2);
    do_xfer(1'b1, 8'h01, 32'h0000_0011, 0);
    do_xfer(1'b0, 8'h02, 32'h0, 0);          idle(1);

    for (int t = 0; t < 60; t++) begin
      int waits;
      waits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TMO - 2, TMO + 4))
                                          : int'($urandom_range(0, 4));
      do_xfer(1'($urandom_range(0, 1)), 8'($urandom), $urandom, waits);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
APB requester that sits directly upstream of the team's APB slave. It accepts single read/write commands over a valid/ready command port and sequences them as IDLE→SETUP→ACCESS APB transfers, holding ACCESS until the slave raises pready. It returns one response per command, carrying read data and an error flag. A wait-state timeout aborts transfers to a hung slave.

Parameters:
DATA_WIDTH, 32, width of pwdata/prdata/cmd_wdata/rsp_rdata
ADDR_WIDTH, 8, width of paddr/cmd_addr
TIMEOUT, 16, maximum ACCESS cycles with pready=0 before abort; 0 disables the timeout

Ports:
pclk  in  1  clock
preset  in  1  reset; synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at a pclk edge
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
rsp_err  out  1  1=timeout abort
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
prdata  in  DATA_WIDTH  APB read data
pready  in  1  slave ready

Behaviour:
- One clock (pclk); reset is synchronous and active-high (preset). All state changes occur on posedge pclk.
- Reset values: state=IDLE; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. preset has priority over all other inputs.
- cmd_ready = (state==IDLE) && !preset. The comb path is from state only; there is no path from cmd_* or pready.
- IDLE: on cmd_valid&&cmd_ready, register cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata. Next state is SETUP.
- SETUP (one cycle): psel=1, penable=0. Next state is ACCESS unconditionally.
- ACCESS: psel=1, penable=1. pready is sampled only in ACCESS.
  - pready=1: complete the transfer.
    - Read: rsp_rdata<=prdata. Write: rsp_rdata<=0.
    - rsp_err<=0, rsp_valid<=1. psel/penable drop. Next state is IDLE.
  - pready=0 and TIMEOUT!=0 and counter==TIMEOUT-1: abort.
    - rsp_valid<=1, rsp_err<=1, rsp_rdata<=0. psel/penable drop. Next state is IDLE.
  - Otherwise: counter++ and stay in ACCESS.
  - The counter clears on entry to SETUP. Counter width is $clog2(TIMEOUT+1), minimum 1.
- Latency with a zero-wait slave: accept at edge N; SETUP in cycle N+1; ACCESS in N+2; rsp_valid high in N+3, which is also the next IDLE/cmd_ready cycle. Minimum spacing between APB transfers is therefore 3 cycles, with psel low for exactly one cycle between back-to-back commands.
- rsp_valid is high for exactly one cycle. There is no backpressure; the consumer must take it. rsp_rdata/rsp_err hold their values until the next response.
- paddr/pwrite/pwdata are stable from SETUP through completion and hold after completion. cmd_* changes while busy are ignored.
- Reset mid-transfer (SETUP or ACCESS): the next edge gives IDLE with psel=penable=0. No rsp_valid is generated for the aborted command.
- pready high in SETUP or IDLE is ignored.
- Unknown/illegal state decodes to IDLE with psel=penable=0.

Decomposition:
- Shared package apb_pkg:
  - apb_state_e enum {IDLE, SETUP, ACCESS}
  - APB_DATA_WIDTH=32, APB_ADDR_WIDTH=8 defaults, which the slave also imports
- One natural sub-module, apb_wait_timer: clear/enable/expire counter parameterised by TIMEOUT, with expire tied off to 0 when TIMEOUT=0.

Test Plan:
1. Write, zero-wait: cmd addr=0x10, wdata=0xDEADBEEF accepted at edge N -> psel=1/penable=0 in N+1; psel=1/penable=1, paddr=0x10, pwdata=0xDEADBEEF, pwrite=1 in N+2; rsp_valid=1, rsp_err=0, rsp_rdata=0 in N+3.
2. Read, 3 wait states: addr=0x04, slave holds pready=0 for 3 ACCESS cycles, then pready=1 with prdata=0xA5A50003 -> ACCESS lasts 4 cycles; rsp_rdata=0xA5A50003, rsp_err=0, rsp_valid pulse 1 cycle.
3. Timeout: TIMEOUT=16, pready stuck 0 -> exactly 16 ACCESS cycles, then psel=penable=0, rsp_valid=1, rsp_err=1, rsp_rdata=0; cmd_ready=1 the same cycle.
4. Reset mid-ACCESS: assert preset for 1 cycle during a wait state -> next edge psel=0, penable=0, state IDLE; no rsp_valid ever for that command.
5. Back-to-back: cmd_valid held with write 0x01 then read 0x02 -> second accepted in the rsp_valid cycle of the first; psel low for exactly 1 cycle between transfers; two responses in order.
6. Busy stability: change cmd_addr to 0xFF and cmd_write during SETUP/ACCESS with cmd_ready=0 -> paddr/pwrite unchanged, no extra transfer issued.
